// File: rtl/rggen_axi4lite_responder.sv
// AXI4-Lite responder that forwards one transaction at a time onto the rggen register bus
// and returns the register block's status/read data as the B or R response.
module rggen_axi4lite_responder #(
   parameter int WRITE_FIRST = 1,
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      axi_awvalid_i,
   output logic                      axi_awready_o,
   input  logic [ADDR_WIDTH-1:0]     axi_awaddr_i,
   input  logic [2:0]                axi_awprot_i,
   input  logic                      axi_wvalid_i,
   output logic                      axi_wready_o,
   input  logic [DATA_WIDTH-1:0]     axi_wdata_i,
   input  logic [DATA_WIDTH/8-1:0]   axi_wstrb_i,
   output logic                      axi_bvalid_o,
   input  logic                      axi_bready_i,
   output logic [1:0]                axi_bresp_o,
   input  logic                      axi_arvalid_i,
   output logic                      axi_arready_o,
   input  logic [ADDR_WIDTH-1:0]     axi_araddr_i,
   input  logic [2:0]                axi_arprot_i,
   output logic                      axi_rvalid_o,
   input  logic                      axi_rready_i,
   output logic [DATA_WIDTH-1:0]     axi_rdata_o,
   output logic [1:0]                axi_rresp_o,
   output logic                      bus_valid_o,
   output logic [ADDR_WIDTH-1:0]     bus_address_o,
   output logic                      bus_write_o,
   output logic [DATA_WIDTH-1:0]     bus_write_data_o,
   output logic [DATA_WIDTH/8-1:0]   bus_strobe_o,
   input  logic                      bus_ready_i,
   input  logic [1:0]                bus_status_i,
   input  logic [DATA_WIDTH-1:0]     bus_read_data_i
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_BUS_ACCESS = 2'd1,
      ST_RESPONSE   = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic                   write_q, write_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0]  strobe_q, strobe_d;
   logic [1:0]             status_q, status_d;
   logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
   logic                   write_req_s;
   logic                   read_req_s;
   logic                   accept_write_s;
   logic                   accept_read_s;
   logic                   resp_done_s;
   logic                   unused_prot_s;

   // Protection attributes carry no meaning for the register block.
   assign unused_prot_s = ^{axi_awprot_i, axi_arprot_i};

   // A write needs AW and W together; ties are broken by WRITE_FIRST, gated off during reset.
   always_comb begin
      write_req_s    = axi_awvalid_i & axi_wvalid_i;
      read_req_s     = axi_arvalid_i;
      accept_write_s = 1'b0;
      accept_read_s  = 1'b0;
      if (i_rst_n && (state_q == ST_IDLE)) begin
         if (WRITE_FIRST != 0) begin
            accept_write_s = write_req_s;
            accept_read_s  = read_req_s & ~write_req_s;
         end else begin
            accept_read_s  = read_req_s;
            accept_write_s = write_req_s & ~read_req_s;
         end
      end else begin
         accept_write_s = 1'b0;
         accept_read_s  = 1'b0;
      end
      resp_done_s = (state_q == ST_RESPONSE) &&
                    (write_q ? axi_bready_i : axi_rready_i);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_write_s || accept_read_s) state_d = ST_BUS_ACCESS;
            else                                 state_d = ST_IDLE;
         end
         ST_BUS_ACCESS: begin
            if (bus_ready_i) state_d = ST_RESPONSE;
            else             state_d = ST_BUS_ACCESS;
         end
         ST_RESPONSE: begin
            if (resp_done_s) state_d = ST_IDLE;
            else             state_d = ST_RESPONSE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Reads present all-ones strobe and zero write data so the register bus sees a clean request.
   always_comb begin
      addr_d   = addr_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      strobe_d = strobe_q;
      status_d = status_q;
      rdata_d  = rdata_q;
      if (accept_write_s) begin
         addr_d   = axi_awaddr_i;
         write_d  = 1'b1;
         wdata_d  = axi_wdata_i;
         strobe_d = axi_wstrb_i;
      end else if (accept_read_s) begin
         addr_d   = axi_araddr_i;
         write_d  = 1'b0;
         wdata_d  = {DATA_WIDTH{1'b0}};
         strobe_d = {STRB_WIDTH{1'b1}};
      end else begin
         addr_d   = addr_q;
         write_d  = write_q;
      end
      if ((state_q == ST_BUS_ACCESS) && bus_ready_i) begin
         status_d = bus_status_i;
         rdata_d  = bus_read_data_i;
      end else begin
         status_d = status_q;
         rdata_d  = rdata_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         addr_q   <= {ADDR_WIDTH{1'b0}};
         write_q  <= 1'b0;
         wdata_q  <= {DATA_WIDTH{1'b0}};
         strobe_q <= {STRB_WIDTH{1'b0}};
         status_q <= 2'd0;
         rdata_q  <= {DATA_WIDTH{1'b0}};
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         strobe_q <= strobe_d;
         status_q <= status_d;
         rdata_q  <= rdata_d;
      end
   end

   always_comb begin
      axi_awready_o    = accept_write_s;
      axi_wready_o     = accept_write_s;
      axi_arready_o    = accept_read_s;
      axi_bvalid_o     = (state_q == ST_RESPONSE) &&  write_q;
      axi_rvalid_o     = (state_q == ST_RESPONSE) && !write_q;
      axi_bresp_o      = status_q;
      axi_rresp_o      = status_q;
      axi_rdata_o      = rdata_q;
      bus_valid_o      = (state_q == ST_BUS_ACCESS);
      bus_address_o    = addr_q;
      bus_write_o      = write_q;
      bus_write_data_o = wdata_q;
      bus_strobe_o     = strobe_q;
   end

endmodule
